expt1_div_unit: RTL and testbench

//  Multi-cycle 32-bit DIV/DIVU engine in execute part 1, fed by the decode-pt2/execute-pt1 pipeline register.

---
 rtl/expt1_div_unit.sv | 141 ++++++++++++++
 tb/tb_expt1_div_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/expt1_div_unit.sv
// Multi-cycle DIV/DIVU engine for execute pt1.
// Radix-2 restoring divider, one quotient bit per cycle; result is {hi=remainder, lo=quotient}.
// Holds the instruction in execute pt1 via stall_req_div until the result is ready.
module expt1_div_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              div_start,
   input  logic              div_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              stage_advance,
   output logic              stall_req_div,
   output logic              div_ready,
   output logic [DATA_W-1:0] div_hi,
   output logic [DATA_W-1:0] div_lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DZERO,
      S_DONE
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_dvs;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_ready;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;

   logic              w_dnd_neg;
   logic              w_dvs_neg;
   logic [DATA_W-1:0] w_dnd_mag;
   logic [DATA_W-1:0] w_dvs_mag;
   logic [DATA_W:0]   w_shift;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W-1:0] w_rem_nxt;
   logic [DATA_W-1:0] w_quo_nxt;
   logic [DATA_W-1:0] w_q_fin;
   logic [DATA_W-1:0] w_r_fin;

   // Operand magnitudes, one restoring step, and sign-corrected final result
   always_comb begin
      w_dnd_neg = div_signed & dividend[DATA_W-1];
      w_dvs_neg = div_signed & divisor[DATA_W-1];
      w_dnd_mag = w_dnd_neg ? -dividend : dividend;
      w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
      // Shifted remainder is DATA_W+1 bits so the trial subtraction cannot overflow;
      // its MSB is then the borrow (trial < 0).
      w_shift   = {r_rem, r_quo[DATA_W-1]};
      w_trial   = w_shift - {1'b0, r_dvs};
      if (!w_trial[DATA_W]) begin
         w_rem_nxt = w_trial[DATA_W-1:0];
         w_quo_nxt = {r_quo[DATA_W-2:0], 1'b1};
      end else begin
         w_rem_nxt = w_shift[DATA_W-1:0];
         w_quo_nxt = {r_quo[DATA_W-2:0], 1'b0};
      end
      w_q_fin = r_neg_q ? -w_quo_nxt : w_quo_nxt;
      w_r_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;
   end

   // Divider control FSM with registered result and ready
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= '0;
         r_dvs   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_ready <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_start) begin
                  if (divisor == '0) begin
                     // quotient register parks the raw dividend for the DZERO cycle
                     r_quo   <= dividend;
                     r_state <= S_DZERO;
                  end else begin
                     r_quo   <= w_dnd_mag;
                     r_dvs   <= w_dvs_mag;
                     r_rem   <= '0;
                     r_neg_q <= w_dnd_neg ^ w_dvs_neg;
                     r_neg_r <= w_dnd_neg;
                     r_cnt   <= '0;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_DZERO: begin
               r_hi    <= r_quo;
               r_lo    <= '1;
               r_ready <= 1'b1;
               r_state <= S_DONE;
            end
            S_BUSY: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(DATA_W - 1)) begin
                  r_hi    <= w_r_fin;
                  r_lo    <= w_q_fin;
                  r_ready <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (stage_advance) begin
                  r_ready <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign stall_req_div = div_start & ~r_ready & ~flush;
   assign div_ready     = r_ready;
   assign div_hi        = r_hi;
   assign div_lo        = r_lo;

endmodule

// File: tb/tb_expt1_div_unit.sv
// Directed self-checking bench for expt1_div_unit.
module tb_expt1_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        div_start;
   logic        div_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        stage_advance;
   logic        stall_req_div;
   logic        div_ready;
   logic [31:0] div_hi;
   logic [31:0] div_lo;

   int n_checks = 0;
   int n_fail   = 0;

   expt1_div_unit #(.DATA_W(32), .CNT_W(6)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .flush         (flush),
      .div_start     (div_start),
      .div_signed    (div_signed),
      .dividend      (dividend),
      .divisor       (divisor),
      .stage_advance (stage_advance),
      .stall_req_div (stall_req_div),
      .div_ready     (div_ready),
      .div_hi        (div_hi),
      .div_lo        (div_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge with the unit in IDLE; that cycle is cycle 0.
   task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
      int cyc;
      int stalls;
      div_start     = 1'b1;
      div_signed    = sgn;
      dividend      = a;
      divisor       = b;
      stage_advance = 1'b0;
      cyc    = 0;
      stalls = 0;
      #1;
      while (!div_ready && cyc < 100) begin
         if (stall_req_div) stalls++;
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            // operands after acceptance must be ignored
            dividend = $urandom;
            divisor  = $urandom;
         end
         #1;
      end
      check({name, " latency"}, 32'(cyc), 32'(exp_lat));
      check({name, " stall cycles"}, 32'(stalls), 32'(exp_lat));
      check({name, " lo"}, div_lo, exp_lo);
      check({name, " hi"}, div_hi, exp_hi);
      check({name, " stall at ready"}, {31'b0, stall_req_div}, 32'd0);
   endtask

   // Retire the result: one advance cycle, then ready must be low.
   task automatic retire(input string name);
      @(negedge clk);
      stage_advance = 1'b1;
      div_start     = 1'b0;
      @(negedge clk);
      stage_advance = 1'b0;
      #1;
      check({name, " ready after advance"}, {31'b0, div_ready}, 32'd0);
   endtask

   initial begin
      logic [31:0] held_hi;
      logic [31:0] held_lo;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vecs[2]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
      vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
      vecs[6]  = '{1'b0, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd7,          33};
      vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
      vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
      vecs[9]  = '{1'b0, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          2};
      vecs[10] = '{1'b0, 32'h1234_5678,  32'd16,         32'h0123_4567,  32'd8,          33};

      resetn        = 1'b0;
      flush         = 1'b0;
      div_start     = 1'b0;
      div_signed    = 1'b0;
      dividend      = '0;
      divisor       = '0;
      stage_advance = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ready", {31'b0, div_ready}, 32'd0);
      check("reset hi", div_hi, 32'd0);
      check("reset lo", div_lo, 32'd0);
      check("reset stall", {31'b0, stall_req_div}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         do_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                vecs[i].lo, vecs[i].hi, vecs[i].lat);
         retire($sformatf("vec%0d", i));
      end

      // Flush in BUSY cycle 10: ready stays low, hi/lo untouched
      held_hi = div_hi;
      held_lo = div_lo;
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b0;
      dividend   = 32'd50;
      divisor    = 32'd7;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush stall gated", {31'b0, stall_req_div}, 32'd0);
      @(negedge clk);
      flush     = 1'b0;
      div_start = 1'b0;
      #1;
      check("flush ready", {31'b0, div_ready}, 32'd0);
      check("flush stall", {31'b0, stall_req_div}, 32'd0);
      check("flush hi held", div_hi, held_hi);
      check("flush lo held", div_lo, held_lo);
      @(negedge clk);
      do_div("post-flush 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // Flush in DONE wins over stage_advance
      @(negedge clk);
      flush         = 1'b1;
      stage_advance = 1'b1;
      div_start     = 1'b0;
      @(negedge clk);
      flush         = 1'b0;
      stage_advance = 1'b0;
      #1;
      check("flush in done ready", {31'b0, div_ready}, 32'd0);
      check("flush in done lo held", div_lo, 32'd3);

      // Async reset mid-BUSY
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b1;
      dividend   = 32'd77;
      divisor    = 32'd5;
      repeat (5) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async reset ready", {31'b0, div_ready}, 32'd0);
      check("async reset hi", div_hi, 32'd0);
      check("async reset lo", div_lo, 32'd0);
      div_start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      do_div("post-reset 12/5", 1'b0, 32'd12, 32'd5, 32'd2, 32'd2, 33);

      // Back-to-back: second DIV accepted in the IDLE cycle right after retirement
      @(negedge clk);
      stage_advance = 1'b1;
      dividend      = 32'd20;
      divisor       = 32'd6;
      @(negedge clk);
      stage_advance = 1'b0;
      #1;
      check("b2b ready dropped", {31'b0, div_ready}, 32'd0);
      check("b2b stall in idle", {31'b0, stall_req_div}, 32'd1);
      do_div("b2b 20/6", 1'b1, 32'd20, 32'd6, 32'd3, 32'd2, 33);
      retire("b2b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
